apb_to_axil_bridge: RTL

- Reverse-direction companion to the AXI4-Lite-to-APB bridge.
- Acts as an APB4 completer (slave) and converts each APB transfer into exactly one AXI4-Lite master transaction.
- Lets APB-side masters (debug/config controllers) reach AXI4-Lite-mapped targets.
- One transfer outstanding at a time. APB wait states (pready low) are held until the AXI response returns.

---
 rtl/apb_to_axil_bridge.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/apb_to_axil_bridge.sv
// APB4 completer that turns each APB transfer into a single AXI4-Lite master transaction.
// One transfer in flight; the APB access phase is stretched until the AXI response returns.
module apb_to_axil_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [STRB_WIDTH-1:0] pstrb,
    input  logic [2:0]            pprot,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
    logic [STRB_WIDTH-1:0]   wstrb_reg, wstrb_next;
    logic [2:0]              prot_reg, prot_next;
    logic                    awvalid_reg, awvalid_next;
    logic                    wvalid_reg, wvalid_next;
    logic                    arvalid_reg, arvalid_next;
    logic                    aw_done_reg, aw_done_next;
    logic                    w_done_reg, w_done_next;
    logic                    bready_reg, bready_next;
    logic                    rready_reg, rready_next;
    logic                    pready_reg, pready_next;
    logic                    pslverr_reg, pslverr_next;
    logic [DATA_WIDTH-1:0]   prdata_reg, prdata_next;
    logic                    aw_fire, w_fire;

    // Only bit 1 of a response separates OKAY/EXOKAY from SLVERR/DECERR.
    logic unused_resp_bits;
    assign unused_resp_bits = m_axi_bresp[0] ^ m_axi_rresp[0];

    assign aw_fire = awvalid_reg & m_axi_awready;
    assign w_fire  = wvalid_reg & m_axi_wready;

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        wstrb_next   = wstrb_reg;
        prot_next    = prot_reg;
        awvalid_next = awvalid_reg;
        wvalid_next  = wvalid_reg;
        arvalid_next = arvalid_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
        bready_next  = bready_reg;
        rready_next  = rready_reg;
        pready_next  = pready_reg;
        pslverr_next = pslverr_reg;
        prdata_next  = prdata_reg;

        case (state_reg)
            IDLE: begin
                // Capture only in the setup phase; a bare access phase is ignored.
                if (psel && !penable) begin
                    addr_next  = paddr;
                    wdata_next = pwdata;
                    wstrb_next = pstrb;
                    prot_next  = pprot;
                    if (pwrite) begin
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                        state_next   = WR_REQ;
                    end else begin
                        arvalid_next = 1'b1;
                        state_next   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (aw_fire) begin
                    awvalid_next = 1'b0;
                    aw_done_next = 1'b1;
                end
                if (w_fire) begin
                    wvalid_next = 1'b0;
                    w_done_next = 1'b1;
                end
                if ((aw_done_reg || aw_fire) && (w_done_reg || w_fire)) begin
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    bready_next  = 1'b1;
                    state_next   = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid && bready_reg) begin
                    bready_next  = 1'b0;
                    pslverr_next = m_axi_bresp[1];
                    prdata_next  = '0;
                    pready_next  = 1'b1;
                    state_next   = DONE;
                end
            end
            RD_REQ: begin
                if (m_axi_arready) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (m_axi_rvalid && rready_reg) begin
                    rready_next  = 1'b0;
                    prdata_next  = m_axi_rdata;
                    pslverr_next = m_axi_rresp[1];
                    pready_next  = 1'b1;
                    state_next   = DONE;
                end
            end
            DONE: begin
                pready_next  = 1'b0;
                pslverr_next = 1'b0;
                prdata_next  = '0;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            prot_reg    <= '0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            arvalid_reg <= 1'b0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            bready_reg  <= 1'b0;
            rready_reg  <= 1'b0;
            pready_reg  <= 1'b0;
            pslverr_reg <= 1'b0;
            prdata_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            wstrb_reg   <= wstrb_next;
            prot_reg    <= prot_next;
            awvalid_reg <= awvalid_next;
            wvalid_reg  <= wvalid_next;
            arvalid_reg <= arvalid_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
            bready_reg  <= bready_next;
            rready_reg  <= rready_next;
            pready_reg  <= pready_next;
            pslverr_reg <= pslverr_next;
            prdata_reg  <= prdata_next;
        end
    end

    assign prdata        = prdata_reg;
    assign pready        = pready_reg;
    assign pslverr       = pslverr_reg;
    assign m_axi_awaddr  = addr_reg;
    assign m_axi_awprot  = prot_reg;
    assign m_axi_awvalid = awvalid_reg;
    assign m_axi_wdata   = wdata_reg;
    assign m_axi_wstrb   = wstrb_reg;
    assign m_axi_wvalid  = wvalid_reg;
    assign m_axi_bready  = bready_reg;
    assign m_axi_araddr  = addr_reg;
    assign m_axi_arprot  = prot_reg;
    assign m_axi_arvalid = arvalid_reg;
    assign m_axi_rready  = rready_reg;

endmodule
